// File: rtl/phi0_pin_conditioner.sv
// Pin front end for the 6507 model: synchronises and deglitches clk0/res/rdy, makes clk0 edge strobes, runs a phi0 watchdog.
// Optional period measurement is built when PHI0_PERIOD_MEAS_EN is defined; otherwise period reads 0.
module phi0_pin_conditioner #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT        = 3,
  parameter int WD_CYCLES   = 4096,
  parameter int PW          = 16
) (
  input  logic          eclk,
  input  logic          ereset,
  input  logic          clk0_pin,
  input  logic          res_pin,
  input  logic          rdy_pin,
  output logic          clk0_f,
  output logic          clk0_rise,
  output logic          clk0_fall,
  output logic          res_n_f,
  output logic          res_n_g,
  output logic          rdy_f,
  output logic          clk_ok,
  output logic [PW-1:0] period
);

  localparam int CW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [CW-1:0] FILT_LAST = CW'(FILT - 1);
  localparam logic [PW-1:0] WD = PW'(WD_CYCLES);
  // bit 0 = clk0, bit 1 = RES_n, bit 2 = RDY; synchronisers and filters reset to these levels
  localparam logic [2:0] RST_VALS = 3'b100;

  typedef enum logic [1:0] {LOST, LOCKING, LOCKED} state_t;

  logic [2:0]    pins;
  logic [2:0]    lvl;
  logic [2:0]    lvl_next;
  logic [PW-1:0] gap;
  logic [1:0]    rise_cnt;
  logic          timeout;
  state_t        state;

  assign pins = {rdy_pin, res_pin, clk0_pin};

  for (genvar i = 0; i < 3; i++) begin : g_pin
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt;
    logic                   lvl_q;
    logic                   s;
    logic                   accept;

    assign s           = sync_q[SYNC_STAGES-1];
    assign accept      = (s != lvl_q) && (cnt == FILT_LAST);
    assign lvl_next[i] = accept ? s : lvl_q;
    assign lvl[i]      = lvl_q;

    always_ff @(posedge eclk or posedge ereset) begin
      if (ereset) begin
        sync_q <= {SYNC_STAGES{RST_VALS[i]}};
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], pins[i]};
      end
    end

    // A new level is taken only after FILT consecutive disagreeing samples
    always_ff @(posedge eclk or posedge ereset) begin
      if (ereset) begin
        lvl_q <= RST_VALS[i];
        cnt   <= '0;
      end else if (s == lvl_q) begin
        cnt <= '0;
      end else if (accept) begin
        lvl_q <= s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign clk0_f  = lvl[0];
  assign res_n_f = lvl[1];
  assign rdy_f   = lvl[2];
  assign res_n_g = res_n_f & clk_ok;

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      clk0_rise <= 1'b0;
      clk0_fall <= 1'b0;
    end else begin
      clk0_rise <= lvl_next[0] & ~lvl[0];
      clk0_fall <= ~lvl_next[0] & lvl[0];
    end
  end

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      gap <= '0;
    end else if (clk0_rise) begin
      gap <= '0;
    end else if (gap != WD) begin
      gap <= gap + 1'b1;
    end
  end

  // Timeout fires on the cycle gap reaches WD; a simultaneous rise keeps the lock
  assign timeout = (gap == WD - 1'b1) && !clk0_rise;

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      state    <= LOST;
      rise_cnt <= '0;
      clk_ok   <= 1'b0;
    end else begin
      unique case (state)
        LOST: begin
          if (clk0_rise) begin
            state    <= LOCKING;
            rise_cnt <= '0;
          end
        end
        LOCKING: begin
          if (clk0_rise) begin
            if (gap < WD) begin
              if (rise_cnt == 2'd1) begin
                state    <= LOCKED;
                clk_ok   <= 1'b1;
                rise_cnt <= '0;
              end else begin
                rise_cnt <= rise_cnt + 1'b1;
              end
            end
          end else if (timeout) begin
            state <= LOST;
          end
        end
        LOCKED: begin
          if (timeout) begin
            state  <= LOST;
            clk_ok <= 1'b0;
          end
        end
        default: begin
          state  <= LOST;
          clk_ok <= 1'b0;
        end
      endcase
    end
  end

`ifdef PHI0_PERIOD_MEAS_EN
  logic [PW-1:0] period_q;
  logic [PW:0]   gap_inc;

  assign gap_inc = {1'b0, gap} + 1'b1;
  assign period  = period_q;

  always_ff @(posedge eclk or posedge ereset) begin
    if (ereset) begin
      period_q <= '0;
    end else if (clk0_rise && state != LOST) begin
      period_q <= gap_inc[PW] ? '1 : gap_inc[PW-1:0];
    end
  end
`else
  assign period = '0;
`endif

endmodule

// File: tb/tb_phi0_pin_conditioner.sv
// Randomised bench for phi0_pin_conditioner against a window/timestamp reference model.
module tb_phi0_pin_conditioner;

  localparam int SYNC = 2;
  localparam int FILT = 3;
  localparam int WD   = 4096;
  localparam int PW   = 16;
  localparam int H    = SYNC + FILT;

  logic          eclk = 1'b0;
  logic          ereset = 1'b1;
  logic          clk0_pin = 1'b0;
  logic          res_pin = 1'b0;
  logic          rdy_pin = 1'b1;
  logic          clk0_f, clk0_rise, clk0_fall, res_n_f, res_n_g, rdy_f, clk_ok;
  logic [PW-1:0] period;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: pin histories (bit k = pin sampled k edges ago), timestamps of rise strobes
  logic [H-1:0] h_clk, h_res, h_rdy;
  bit m_clk, m_res, m_rdy, m_rise, m_fall;
  int m_state;
  int m_n;
  int m_period;
  int c, lr, plr;
  int res_hold, rdy_hold;

  phi0_pin_conditioner #(
    .SYNC_STAGES(SYNC), .FILT(FILT), .WD_CYCLES(WD), .PW(PW)
  ) dut (
    .eclk(eclk), .ereset(ereset), .clk0_pin(clk0_pin), .res_pin(res_pin), .rdy_pin(rdy_pin),
    .clk0_f(clk0_f), .clk0_rise(clk0_rise), .clk0_fall(clk0_fall), .res_n_f(res_n_f),
    .res_n_g(res_n_g), .rdy_f(rdy_f), .clk_ok(clk_ok), .period(period)
  );

  always #5 eclk = ~eclk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    h_clk = '0; h_res = '0; h_rdy = '1;
    m_clk = 1'b0; m_res = 1'b0; m_rdy = 1'b1;
    m_rise = 1'b0; m_fall = 1'b0;
    m_state = 0; m_n = 0; m_period = 0;
    c = 0; lr = -1; plr = -1;
  endtask

  // A level is accepted when the FILT samples that have just left the synchroniser all disagree with it
  function automatic bit filt_next(input logic [H-1:0] h, input bit cur);
    logic [FILT-1:0] win;
    win = h[H-1:SYNC];
    if (win == {FILT{~cur}}) return ~cur;
    return cur;
  endfunction

  task automatic model_step();
    bit rise_prev, nclk;
    int base, gap_prev, per;
    c++;
    rise_prev = (lr == c - 1);
    base = rise_prev ? plr : lr;
    gap_prev = (c - 1) - base - 1;
    if (gap_prev > WD) gap_prev = WD;
    if (rise_prev) begin
      if (m_state == 0) begin
        m_state = 1;
        m_n = 0;
      end else begin
        per = gap_prev + 1;
        m_period = (per > 2**PW - 1) ? 2**PW - 1 : per;
        if (m_state == 1 && gap_prev < WD) begin
          m_n++;
          if (m_n == 2) m_state = 2;
        end
      end
    end else if (m_state != 0 && gap_prev == WD - 1) begin
      m_state = 0;
    end
    h_clk = {h_clk[H-2:0], clk0_pin};
    h_res = {h_res[H-2:0], res_pin};
    h_rdy = {h_rdy[H-2:0], rdy_pin};
    nclk = filt_next(h_clk, m_clk);
    m_rise = nclk & ~m_clk;
    m_fall = ~nclk & m_clk;
    m_clk = nclk;
    m_res = filt_next(h_res, m_res);
    m_rdy = filt_next(h_rdy, m_rdy);
    if (m_rise) begin
      plr = lr;
      lr = c;
    end
  endtask

  task automatic check_all();
    bit ok;
    ok = (m_state == 2);
    checkOutput("clk0_f", 32'(clk0_f), 32'(m_clk));
    checkOutput("clk0_rise", 32'(clk0_rise), 32'(m_rise));
    checkOutput("clk0_fall", 32'(clk0_fall), 32'(m_fall));
    checkOutput("res_n_f", 32'(res_n_f), 32'(m_res));
    checkOutput("res_n_g", 32'(res_n_g), 32'(m_res & ok));
    checkOutput("rdy_f", 32'(rdy_f), 32'(m_rdy));
    checkOutput("clk_ok", 32'(clk_ok), 32'(ok));
`ifdef PHI0_PERIOD_MEAS_EN
    checkOutput("period", 32'(period), 32'(m_period));
`else
    checkOutput("period", 32'(period), 32'd0);
`endif
  endtask

  task automatic cycle();
    @(posedge eclk);
    if (!ereset) model_step();
    #1;
    check_all();
  endtask

  task automatic applyStimulus(input bit lvl, input int n);
    for (int i = 0; i < n; i++) begin
      clk0_pin = lvl;
      if (res_hold == 0) begin
        res_pin = ~res_pin;
        res_hold = res_pin ? int'($urandom_range(10, 60)) : int'($urandom_range(1, 14));
      end else begin
        res_hold--;
      end
      if (rdy_hold == 0) begin
        rdy_pin = ~rdy_pin;
        rdy_hold = rdy_pin ? int'($urandom_range(8, 50)) : int'($urandom_range(1, 10));
      end else begin
        rdy_hold--;
      end
      cycle();
    end
  endtask

  task automatic run_clock(input int periods, input int lo, input int hi, input bit glitches);
    int half, g;
    for (int p = 0; p < periods; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        half = int'($urandom_range(lo, hi));
        if (glitches && half >= 12 && $urandom_range(0, 3) == 0) begin
          g = int'($urandom_range(1, 4));
          applyStimulus(ph == 0, 4);
          applyStimulus(ph != 0, g);
          applyStimulus(ph == 0, half - 4 - g);
        end else begin
          applyStimulus(ph == 0, half);
        end
      end
    end
  endtask

  task automatic pulse_reset();
    #2 ereset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge eclk);
    #1;
    check_all();
    #1 ereset = 1'b0;
  endtask

  initial begin
    model_reset();
    res_hold = 5;
    rdy_hold = 5;
    for (int i = 0; i < 8; i++) begin
      clk0_pin = 1'($urandom);
      res_pin  = 1'($urandom);
      rdy_pin  = 1'($urandom);
      cycle();
    end
    ereset = 1'b0;
    res_pin = 1'b1;
    rdy_pin = 1'b1;
    res_hold = 40;
    rdy_hold = 30;

    for (int p = 0; p < 6; p++) begin
      applyStimulus(1'b1, 33);
      applyStimulus(1'b0, 33);
    end
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 2);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 3);
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 30);
    applyStimulus(1'b0, WD + 50);

    run_clock(5, 10, 60, 1'b0);
    applyStimulus(1'b1, 12);
    pulse_reset();
    applyStimulus(1'b1, 20);
    run_clock(5, 10, 60, 1'b0);

    for (int r = 0; r < 6; r++) begin
      run_clock(int'($urandom_range(2, 8)), 6, 80, 1'b1);
    end
    applyStimulus(1'b1, WD + 30);
    run_clock(6, 8, 50, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
